// File: rtl/ascii2hex.sv
// ASCII-to-hex assembler: decodes hex-digit characters from a strobed byte stream
// and packs HEX_BIT_WIDTH digits (MSB first) into one word. Option: ASCII2HEX_LOWER_EN.
module ascii2hex #(
  parameter int HEX_BIT_WIDTH  = 2,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         ascii_den_i,
  input  logic [7:0]                   ascii_data_i,
  output logic                         hex_den_o,
  output logic [HEX_BIT_WIDTH*4-1:0]   hex_data_o,
  output logic                         hex_err_o,
  output logic                         busy_o
);

  localparam int W  = HEX_BIT_WIDTH * 4;
  localparam int CW = $clog2(HEX_BIT_WIDTH + 1);
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state, state_next;
  logic [1:0]      hist;
  logic [7:0]      data;
  logic [CW-1:0]   cnt, cnt_next;
  logic [W-1:0]    shift, shift_next, shift_in, word_next;
  logic [TW-1:0]   timer, timer_next;
  logic            den_next, err_next, busy_next;
  logic            rz, is_digit, is_sep, timeout;
  logic [3:0]      nibble;

  assign rz = (hist == 2'b01);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist       <= 2'b00;
      data       <= 8'h00;
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      timer      <= '0;
      hex_den_o  <= 1'b0;
      hex_err_o  <= 1'b0;
      hex_data_o <= '0;
      busy_o     <= 1'b0;
    end else begin
      hist       <= {hist[0], ascii_den_i};
      data       <= ascii_data_i;
      state      <= state_next;
      cnt        <= cnt_next;
      shift      <= shift_next;
      timer      <= timer_next;
      hex_den_o  <= den_next;
      hex_err_o  <= err_next;
      hex_data_o <= word_next;
      busy_o     <= busy_next;
    end
  end

  always_comb begin
    is_digit = 1'b0;
    is_sep   = 1'b0;
    nibble   = 4'h0;
    if (data >= 8'h30 && data <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = data[3:0];
    end else if (data >= 8'h41 && data <= 8'h46) begin
      is_digit = 1'b1;
      nibble   = data[3:0] + 4'd9;
`ifdef ASCII2HEX_LOWER_EN
    end else if (data >= 8'h61 && data <= 8'h66) begin
      is_digit = 1'b1;
      nibble   = data[3:0] + 4'd9;
`endif
    end else if (data == 8'h0D || data == 8'h0A || data == 8'h20) begin
      is_sep = 1'b1;
    end
  end

  // For a single-digit word the shift term vanishes and only the nibble remains.
  assign shift_in = (shift << 4) | W'(nibble);
  assign timeout  = (TIMEOUT_CYCLES != 0) && (timer == TW'(TIMEOUT_CYCLES));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_next = shift;
    word_next  = hex_data_o;
    den_next   = 1'b0;
    err_next   = 1'b0;
    timer_next = timer;

    if (rz || state == IDLE)
      timer_next = '0;
    else if (timer != '1)
      timer_next = timer + TW'(1);

    if (state == IDLE) begin
      if (rz) begin
        if (is_digit) begin
          if (HEX_BIT_WIDTH == 1) begin
            word_next = shift_in;
            den_next  = 1'b1;
          end else begin
            shift_next = shift_in;
            cnt_next   = CW'(1);
            state_next = COLLECT;
          end
        end else if (!is_sep) begin
          err_next = 1'b1;
        end
      end
    end else begin
      // rz is checked first so a character arriving on the timeout cycle wins.
      if (rz && is_digit) begin
        if (cnt == CW'(HEX_BIT_WIDTH - 1)) begin
          word_next  = shift_in;
          den_next   = 1'b1;
          cnt_next   = '0;
          shift_next = '0;
          state_next = IDLE;
        end else begin
          shift_next = shift_in;
          cnt_next   = cnt + CW'(1);
        end
      end else if (rz || timeout) begin
        err_next   = 1'b1;
        cnt_next   = '0;
        shift_next = '0;
        state_next = IDLE;
      end
    end

    busy_next = (state_next == COLLECT);
  end

endmodule

// File: tb/tb_ascii2hex.sv
// Directed bench for ascii2hex: vector table for word assembly plus hand
// sequences for latency, held strobe, reset mid-word, timeout and N=4.
module tb_ascii2hex;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        den;
  logic [7:0]  data;

  logic        den2, err2, busy2;
  logic [7:0]  hex2;
  logic        den4, err4, busy4;
  logic [15:0] hex4;
  logic        dent, errt, busyt;
  logic [7:0]  hext;

  always #5 clk = ~clk;

  ascii2hex #(.HEX_BIT_WIDTH(2), .TIMEOUT_CYCLES(0)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .ascii_den_i(den), .ascii_data_i(data),
    .hex_den_o(den2), .hex_data_o(hex2), .hex_err_o(err2), .busy_o(busy2));

  ascii2hex #(.HEX_BIT_WIDTH(4), .TIMEOUT_CYCLES(0)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .ascii_den_i(den), .ascii_data_i(data),
    .hex_den_o(den4), .hex_data_o(hex4), .hex_err_o(err4), .busy_o(busy4));

  ascii2hex #(.HEX_BIT_WIDTH(2), .TIMEOUT_CYCLES(16)) dutt (
    .clk_i(clk), .rst_ni(rst_n), .ascii_den_i(den), .ascii_data_i(data),
    .hex_den_o(dent), .hex_data_o(hext), .hex_err_o(errt), .busy_o(busyt));

  int cyc = 0, n_den2 = 0, n_err2 = 0, n_den4 = 0, n_errt = 0, n_dent = 0;
  int both_viol = 0, errt_cyc = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (den2) n_den2 <= n_den2 + 1;
    if (err2) n_err2 <= n_err2 + 1;
    if (den4) n_den4 <= n_den4 + 1;
    if (dent) n_dent <= n_dent + 1;
    if (errt) begin
      n_errt   <= n_errt + 1;
      errt_cyc <= cyc;
    end
    if ((den2 && err2) || (den4 && err4) || (dent && errt)) both_viol <= both_viol + 1;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_len(input logic [7:0] c, input int hi);
    data = c;
    den  = 1'b1;
    repeat (hi) @(negedge clk);
    den = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] c);
    send_len(c, 2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    string      name;
    logic [7:0] c0;
    logic [7:0] c1;
    int         nden;
    int         nerr;
    logic [7:0] word;
  } vec_t;

  vec_t vt[8];

  initial begin
    int b_den, b_err, b_dent, b_errt, b_den4, c5;
    logic [7:0] lastd;

`ifdef ASCII2HEX_LOWER_EN
    lastd = 8'hAB;
    vt[3] = '{"lower_ab", 8'h61, 8'h62, 1, 0, 8'hAB};
`else
    lastd = 8'h12;
    vt[3] = '{"lower_ab", 8'h61, 8'h62, 0, 2, 8'h12};
`endif
    vt[0] = '{"word_3F",  8'h33, 8'h46, 1, 0, 8'h3F};
    vt[1] = '{"bad_AG",   8'h41, 8'h47, 0, 1, 8'h3F};
    vt[2] = '{"word_12",  8'h31, 8'h32, 1, 0, 8'h12};
    vt[4] = '{"sep_idle", 8'h0D, 8'h0A, 0, 0, lastd};
    vt[5] = '{"sep_9CR",  8'h39, 8'h0D, 0, 1, lastd};
    vt[6] = '{"word_99",  8'h39, 8'h39, 1, 0, 8'h99};
    vt[7] = '{"bad_Z@",   8'h5A, 8'h40, 0, 2, 8'h99};

    rst_n = 1'b0;
    den   = 1'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(hex2), 32'h0);
    chk("rst_den",  32'(den2), 32'h0);
    chk("rst_err",  32'(err2), 32'h0);
    chk("rst_busy", 32'(busy2), 32'h0);
    chk("rst_data4", 32'(hex4), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cycle-exact latency of the completing digit.
    send(8'h33);
    chk("busy_between", 32'(busy2), 32'h1);
    data = 8'h46;
    den  = 1'b1;
    @(negedge clk);
    chk("lat_e0", 32'(den2), 32'h0);
    @(negedge clk);
    chk("lat_e1_den", 32'(den2), 32'h1);
    chk("lat_e1_data", 32'(hex2), 32'h3F);
    chk("lat_e1_busy", 32'(busy2), 32'h0);
    den = 1'b0;
    @(negedge clk);
    chk("lat_e2_den", 32'(den2), 32'h0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      b_den = n_den2;
      b_err = n_err2;
      send(vt[i].c0);
      send(vt[i].c1);
      repeat (3) @(negedge clk);
      chk({vt[i].name, "_den"},  32'(n_den2 - b_den), 32'(vt[i].nden));
      chk({vt[i].name, "_err"},  32'(n_err2 - b_err), 32'(vt[i].nerr));
      chk({vt[i].name, "_data"}, 32'(hex2), 32'(vt[i].word));
      chk({vt[i].name, "_busy"}, 32'(busy2), 32'h0);
    end

    // Strobe held high: one character per rising edge.
    b_den = n_den2;
    b_err = n_err2;
    send_len(8'h31, 20);
    send_len(8'h32, 20);
    repeat (3) @(negedge clk);
    chk("held_den", 32'(n_den2 - b_den), 32'h1);
    chk("held_err", 32'(n_err2 - b_err), 32'h0);
    chk("held_data", 32'(hex2), 32'h12);

    // Reset in the middle of a word.
    send(8'h34);
    chk("mid_busy", 32'(busy2), 32'h1);
    b_den = n_den2;
    b_err = n_err2;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_data", 32'(hex2), 32'h0);
    chk("mid_rst_busy", 32'(busy2), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h35);
    send(8'h36);
    repeat (3) @(negedge clk);
    chk("mid_den", 32'(n_den2 - b_den), 32'h1);
    chk("mid_err", 32'(n_err2 - b_err), 32'h0);
    chk("mid_data", 32'(hex2), 32'h56);

    // Inter-character timeout on the TIMEOUT_CYCLES=16 instance.
    do_reset();
    b_errt = n_errt;
    b_err  = n_err2;
    c5 = cyc;
    send(8'h35);
    chk("to_busy_start", 32'(busyt), 32'h1);
    repeat (30) @(negedge clk);
    chk("to_err_count", 32'(n_errt - b_errt), 32'h1);
    chk("to_window", 32'((errt_cyc - c5 >= 15) && (errt_cyc - c5 <= 21)), 32'h1);
    chk("to_busy_end", 32'(busyt), 32'h0);
    chk("to_off_err", 32'(n_err2 - b_err), 32'h0);
    chk("to_off_busy", 32'(busy2), 32'h1);
    b_dent = n_dent;
    send(8'h37);
    send(8'h38);
    repeat (3) @(negedge clk);
    chk("to_next_den", 32'(n_dent - b_dent), 32'h1);
    chk("to_next_data", 32'(hext), 32'h78);

    // Four-digit word.
    do_reset();
    b_den4 = n_den4;
    send(8'h42);
    send(8'h45);
    send(8'h45);
    chk("n4_busy", 32'(busy4), 32'h1);
    send(8'h46);
    repeat (3) @(negedge clk);
    chk("n4_den", 32'(n_den4 - b_den4), 32'h1);
    chk("n4_data", 32'(hex4), 32'hBEEF);
    chk("n4_busy_end", 32'(busy4), 32'h0);

    chk("den_err_exclusive", 32'(both_viol), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
